// File: rtl/hex_scroll_feeder_if.sv
// hex_scroll_feeder_if: load handshake and display bundle for the HEX feeder.
// master drives load_valid/load_data/scroll_en; slave returns ready, window, busy.
interface hex_scroll_feeder_if #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 6
);
   logic                  load_valid;
   logic [WIDTH-1:0]      load_data;
   logic                  load_ready;
   logic                  scroll_en;
   logic [4*DIGITS-1:0]   digits;
   logic [DIGITS-1:0]     blank;
   logic                  busy;

   modport master (
      output load_valid,
      output load_data,
      output scroll_en,
      input  load_ready,
      input  digits,
      input  blank,
      input  busy
   );

   modport slave (
      input  load_valid,
      input  load_data,
      input  scroll_en,
      output load_ready,
      output digits,
      output blank,
      output busy
   );
endinterface

// File: rtl/hex_scroll_feeder.sv
// hex_scroll_feeder: latches a word and presents a scrolling DIGITS-nibble window.
// Ports: clk, reset (async, active-high), bus (slave: load_valid/load_data/load_ready,
// scroll_en, digits, blank, busy). Macro HEX_SCROLL_LZ_BLANK_EN adds leading-zero blanking.
module hex_scroll_feeder #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 6,
   parameter int TICKS  = 25000000
) (
   input  logic                 clk,
   input  logic                 reset,
   hex_scroll_feeder_if.slave   bus
);

   localparam int NN = WIDTH / 4;
   localparam int L  = NN + DIGITS;
   localparam int PW = $clog2(L);
   localparam int CW = $clog2(TICKS);
   localparam int MW = (NN > 1) ? $clog2(NN) : 1;

   localparam logic [CW-1:0] TMAX = CW'(TICKS - 1);
   localparam logic [PW-1:0] PMAX = PW'(L - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_SCROLL
   } state_t;

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      data_q, data_d;
   logic [PW-1:0]         pos_q, pos_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [4*DIGITS-1:0]   digits_q, digits_d;
   logic [DIGITS-1:0]     blank_q, blank_d;
   logic                  busy_q;
   logic                  load_ready;
   logic                  accept;

`ifdef HEX_SCROLL_LZ_BLANK_EN
   logic [MW-1:0]         m_q, m_d, m_new;

   // Index of the highest nonzero nibble; zero word gives 0.
   always_comb begin
      m_new = '0;
      for (int k = 0; k < NN; k++) begin
         if (bus.load_data[4*k +: 4] != 4'h0) begin
            m_new = MW'(k);
         end
      end
   end
`endif

   // A new word may only start when the message is at its first position.
   assign load_ready = (state_q != S_SCROLL) || (pos_q == '0);
   assign accept     = bus.load_valid & load_ready;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      pos_d   = pos_q;
      cnt_d   = cnt_q;
`ifdef HEX_SCROLL_LZ_BLANK_EN
      m_d     = m_q;
`endif
      if (accept) begin
         data_d  = bus.load_data;
         pos_d   = '0;
         cnt_d   = '0;
         state_d = bus.scroll_en ? S_SCROLL : S_HOLD;
`ifdef HEX_SCROLL_LZ_BLANK_EN
         m_d     = m_new;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: begin
            end
            S_HOLD: begin
               if (bus.scroll_en) begin
                  state_d = S_SCROLL;
                  cnt_d   = '0;
               end
            end
            S_SCROLL: begin
               if (!bus.scroll_en) begin
                  state_d = S_HOLD;
                  cnt_d   = '0;
               end else if (cnt_q == TMAX) begin
                  cnt_d = '0;
                  pos_d = (pos_q == PMAX) ? '0 : pos_q + PW'(1);
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Window is built from next-state values so the registered
   // outputs track the event by exactly one clock.
   always_comb begin
      logic [PW:0]      slot;
      logic [WIDTH-1:0] sh;
      logic             dark;
      digits_d = '0;
      blank_d  = '1;
      for (int i = 0; i < DIGITS; i++) begin
         slot = {1'b0, pos_d} + (PW+1)'(i);
         if (slot >= (PW+1)'(L)) begin
            slot = slot - (PW+1)'(L);
         end
         sh   = data_d >> {slot, 2'b00};
         dark = (state_d == S_IDLE) || (slot >= (PW+1)'(NN));
`ifdef HEX_SCROLL_LZ_BLANK_EN
         if (slot > (PW+1)'(m_d)) begin
            dark = 1'b1;
         end
`endif
         blank_d[i] = dark;
         digits_d[4*i +: 4] = dark ? 4'h0 : sh[3:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         data_q   <= '0;
         pos_q    <= '0;
         cnt_q    <= '0;
         digits_q <= '0;
         blank_q  <= '1;
         busy_q   <= 1'b0;
`ifdef HEX_SCROLL_LZ_BLANK_EN
         m_q      <= '0;
`endif
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         pos_q    <= pos_d;
         cnt_q    <= cnt_d;
         digits_q <= digits_d;
         blank_q  <= blank_d;
         busy_q   <= (state_d == S_SCROLL);
`ifdef HEX_SCROLL_LZ_BLANK_EN
         m_q      <= m_d;
`endif
      end
   end

   assign bus.load_ready = load_ready;
   assign bus.digits     = digits_q;
   assign bus.blank      = blank_q;
   assign bus.busy       = busy_q;

endmodule
